// File: rtl/alu_uart_ctrl.sv
// alu_uart_ctrl: collects operand A, operand B and an op code from a UART byte stream,
// drives an external ALU and sends the result byte back (plus an optional flag byte).
// Latency: op byte rx (cycle N) -> o_op_code N+1 -> result latched N+2 -> o_tx_start N+3.
// Backpressure: TX start waits for i_tx_busy low; rx bytes during execute/transmit are dropped.
//
// Ports:
//   clock, i_reset_n        single clock, asynchronous active-low reset
//   i_rx_data/i_rx_done     received byte and its one-cycle strobe
//   i_tx_busy               UART transmitter busy
//   i_alu_result/zero/carry combinational ALU outputs for the registered operands
//   o_data_a/o_data_b       registered ALU operands
//   o_op_code               registered ALU op code
//   o_tx_data/o_tx_start    byte to send, held stable until the transmitter finishes
//   o_busy                  high whenever a sequence is in progress
//   o_op_error/o_timeout    one-cycle abort pulses
//
// Optional feature: define ALU_UART_CTRL_FLAGS_EN to send a second byte
// {zeros, carry, zero} after each result byte.

module alu_uart_ctrl #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP_CODE     = 6,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  clock,
    input  logic                  i_reset_n,
    input  logic [NB_DATA-1:0]    i_rx_data,
    input  logic                  i_rx_done,
    input  logic                  i_tx_busy,
    input  logic [NB_DATA-1:0]    i_alu_result,
    input  logic                  i_alu_zero,
    input  logic                  i_alu_carry,
    output logic [NB_DATA-1:0]    o_data_a,
    output logic [NB_DATA-1:0]    o_data_b,
    output logic [NB_OP_CODE-1:0] o_op_code,
    output logic [NB_DATA-1:0]    o_tx_data,
    output logic                  o_tx_start,
    output logic                  o_busy,
    output logic                  o_op_error,
    output logic                  o_timeout
);

    localparam logic [2:0] S_WAIT_A   = 3'd0;
    localparam logic [2:0] S_WAIT_B   = 3'd1;
    localparam logic [2:0] S_WAIT_OP  = 3'd2;
    localparam logic [2:0] S_EXEC     = 3'd3;
    localparam logic [2:0] S_TX_RES   = 3'd4;
    localparam logic [2:0] S_WAIT_TX  = 3'd5;
`ifdef ALU_UART_CTRL_FLAGS_EN
    localparam logic [2:0] S_TX_FLG   = 3'd6;
    localparam logic [2:0] S_WAIT_TX2 = 3'd7;
`endif

    localparam logic [NB_OP_CODE-1:0] OP_ADD = NB_OP_CODE'('h20);
    localparam logic [NB_OP_CODE-1:0] OP_SUB = NB_OP_CODE'('h22);
    localparam logic [NB_OP_CODE-1:0] OP_AND = NB_OP_CODE'('h24);
    localparam logic [NB_OP_CODE-1:0] OP_OR  = NB_OP_CODE'('h25);
    localparam logic [NB_OP_CODE-1:0] OP_XOR = NB_OP_CODE'('h26);
    localparam logic [NB_OP_CODE-1:0] OP_SRA = NB_OP_CODE'('h03);
    localparam logic [NB_OP_CODE-1:0] OP_SRL = NB_OP_CODE'('h02);
    localparam logic [NB_OP_CODE-1:0] OP_NOR = NB_OP_CODE'('h27);

    // Counter only needs to reach TIMEOUT_CYCLES-1: the expiry cycle itself
    // is the one where the counter already holds that value.
    localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] tmo_cnt;
    logic [1:0]       flag_q;        // {carry, zero} captured with the result
    logic             tx_seen_busy;  // transmitter has picked up the current byte
    logic             op_ok;
    logic             tmo_hit;

    // Op byte is accepted only with all bits above the op field clear.
    always_comb begin
        op_ok = 1'b0;
        case (i_rx_data[NB_OP_CODE-1:0])
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SRA, OP_SRL, OP_NOR: op_ok = 1'b1;
            default:                        op_ok = 1'b0;
        endcase
        if ((i_rx_data >> NB_OP_CODE) != '0) begin
            op_ok = 1'b0;
        end
    end

    assign tmo_hit = (tmo_cnt == CNT_LAST);
    assign o_busy  = (state != S_WAIT_A);

`ifndef ALU_UART_CTRL_FLAGS_EN
    // Flags are captured in every build but only transmitted with the feature on.
    logic unused_flags;
    assign unused_flags = ^flag_q;
`endif

    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= S_WAIT_A;
            tmo_cnt      <= '0;
            flag_q       <= 2'b00;
            tx_seen_busy <= 1'b0;
            o_data_a     <= '0;
            o_data_b     <= '0;
            o_op_code    <= '0;
            o_tx_data    <= '0;
            o_tx_start   <= 1'b0;
            o_op_error   <= 1'b0;
            o_timeout    <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            o_op_error <= 1'b0;
            o_timeout  <= 1'b0;

            case (state)
                S_WAIT_A: begin
                    if (i_rx_done) begin
                        o_data_a <= i_rx_data;
                        tmo_cnt  <= '0;
                        state    <= S_WAIT_B;
                    end
                end

                // A byte arriving on the expiry cycle is still accepted.
                S_WAIT_B: begin
                    if (i_rx_done) begin
                        o_data_b <= i_rx_data;
                        tmo_cnt  <= '0;
                        state    <= S_WAIT_OP;
                    end else if (tmo_hit) begin
                        o_timeout <= 1'b1;
                        tmo_cnt   <= '0;
                        state     <= S_WAIT_A;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end

                S_WAIT_OP: begin
                    if (i_rx_done) begin
                        tmo_cnt <= '0;
                        if (op_ok) begin
                            o_op_code <= i_rx_data[NB_OP_CODE-1:0];
                            state     <= S_EXEC;
                        end else begin
                            o_op_error <= 1'b1;
                            state      <= S_WAIT_A;
                        end
                    end else if (tmo_hit) begin
                        o_timeout <= 1'b1;
                        tmo_cnt   <= '0;
                        state     <= S_WAIT_A;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end

                // ALU has had one full cycle with the new op code.
                S_EXEC: begin
                    o_tx_data <= i_alu_result;
                    flag_q    <= {i_alu_carry, i_alu_zero};
                    state     <= S_TX_RES;
                end

                S_TX_RES: begin
                    if (!i_tx_busy) begin
                        o_tx_start   <= 1'b1;
                        tx_seen_busy <= 1'b0;
                        state        <= S_WAIT_TX;
                    end
                end

                // Done only after busy has been seen high and then low again.
                S_WAIT_TX: begin
                    if (i_tx_busy) begin
                        tx_seen_busy <= 1'b1;
                    end else if (tx_seen_busy) begin
`ifdef ALU_UART_CTRL_FLAGS_EN
                        state <= S_TX_FLG;
`else
                        state <= S_WAIT_A;
`endif
                    end
                end

`ifdef ALU_UART_CTRL_FLAGS_EN
                // Data and start change together so the byte is stable from the start pulse.
                S_TX_FLG: begin
                    if (!i_tx_busy) begin
                        o_tx_data    <= {{(NB_DATA-2){1'b0}}, flag_q};
                        o_tx_start   <= 1'b1;
                        tx_seen_busy <= 1'b0;
                        state        <= S_WAIT_TX2;
                    end
                end

                S_WAIT_TX2: begin
                    if (i_tx_busy) begin
                        tx_seen_busy <= 1'b1;
                    end else if (tx_seen_busy) begin
                        state <= S_WAIT_A;
                    end
                end
`endif

                default: state <= S_WAIT_A;
            endcase
        end
    end

endmodule
